// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch stage
package fetch_pkg;
  localparam logic [1:0] REQ = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch (pc, imem req/rsp, decode hand-off, redirect with in-flight kill)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
);
  logic [1:0] state;
  logic [31:0] fetch_pc;
  logic [31:0] pc_next;
  logic kill;
  logic hs;
  logic stay_wait;
  assign hs = (state == REQ) && imem_req_ready;
  assign stay_wait = hs || (state == WAIT && !imem_rsp_valid);
  assign imem_req_valid = (state == REQ) && !rst;
  assign instr_valid = state == HOLD;
  assign imem_addr = fetch_pc;
  assign opcode = instr[6:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= REQ;
      fetch_pc <= RESET_PC;
      pc_next <= RESET_PC;
      pc_out <= RESET_PC;
      instr <= NOP_INSTR;
      kill <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target & ~32'd3;
      state <= stay_wait ? WAIT : REQ;
      kill <= stay_wait;
    end else begin
      case (state)
        REQ: if (imem_req_ready) begin
          pc_next <= fetch_pc;
          fetch_pc <= fetch_pc + 32'd4;
          state <= WAIT;
        end
        WAIT: if (imem_rsp_valid) begin
          state <= kill ? REQ : HOLD;
          kill <= 1'b0;
          if (!kill) begin
            instr <= imem_rsp_data;
            pc_out <= pc_next;
          end
        end
        HOLD: if (instr_ready) state <= REQ;
        default: state <= REQ;
      endcase
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized run against a fetch-stream reference model
module tb_fetch_unit;
  import fetch_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req_valid;
  logic imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic [31:0] instr;
  logic [6:0] opcode;
  logic [31:0] pc_out;
  logic instr_valid;
  logic instr_ready = 1'b0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr(instr), .opcode(opcode), .pc_out(pc_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target)
  );
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got %b exp 0", instr_valid); end
    checks++; if (instr !== NOP_INSTR) begin errors++; $display("FAIL rst_instr got %h exp %h", instr, NOP_INSTR); end
    checks++; if (opcode !== OPCODE_OP_IMM) begin errors++; $display("FAIL rst_opcode got %b exp %b", opcode, OPCODE_OP_IMM); end
    checks++; if (pc_out !== RESET_PC) begin errors++; $display("FAIL rst_pc_out got %h exp %h", pc_out, RESET_PC); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr got %h exp %h", imem_addr, RESET_PC); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got v=%b a=%h exp v=1 a=0", imem_req_valid, imem_addr); end
  endtask
  task automatic test_basic;
    imem_req_ready = 1'b1;
    tick;
    checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL wait_outputs got rv=%b iv=%b exp 0 0", imem_req_valid, instr_valid); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0050_0093;
    tick;
    imem_rsp_valid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr got v=%b %h exp v=1 00500093", instr_valid, instr); end
    checks++; if (opcode !== 7'b0010011 || pc_out !== 32'h0) begin errors++; $display("FAIL basic_opc_pc got %b %h exp 0010011 0", opcode, pc_out); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL basic_no_req got %b exp 0", imem_req_valid); end
    instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL basic_next got v=%b a=%h exp v=1 a=4", imem_req_valid, imem_addr); end
  endtask
  task automatic test_stall;
    tick;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h00A0_0113;
    tick;
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (instr_valid !== 1'b1 || instr !== 32'h00A0_0113 || pc_out !== 32'h4 || imem_req_valid !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b %h pc=%h rv=%b exp v=1 00a00113 pc=4 rv=0", i, instr_valid, instr, pc_out, imem_req_valid);
      end
      tick;
    end
    instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_next got v=%b a=%h exp v=1 a=8", imem_req_valid, imem_addr); end
  endtask
  task automatic test_redirect_handshake;
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    tick;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    tick;
    imem_rsp_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin
      errors++; $display("FAIL rhs_drop got iv=%b rv=%b a=%h exp iv=0 rv=1 a=40", instr_valid, imem_req_valid, imem_addr);
    end
    tick;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h00C0_0193;
    tick;
    imem_rsp_valid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h40 || instr !== 32'h00C0_0193) begin
      errors++; $display("FAIL rhs_deliver got v=%b pc=%h %h exp v=1 pc=40 00c00193", instr_valid, pc_out, instr);
    end
    instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0;
    checks++; if (imem_addr !== 32'h44) begin errors++; $display("FAIL rhs_next got %h exp 44", imem_addr); end
  endtask
  task automatic test_redirect_wait;
    tick;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h103;
    tick;
    redirect_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rw_waiting got rv=%b iv=%b exp 0 0", imem_req_valid, instr_valid); end
    tick;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h1234_5678;
    tick;
    imem_rsp_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL rw_drop got iv=%b rv=%b a=%h exp iv=0 rv=1 a=100", instr_valid, imem_req_valid, imem_addr);
    end
  endtask
  task automatic test_wrap;
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFE;
    tick;
    redirect_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redir got v=%b a=%h exp v=1 a=fffffffc", imem_req_valid, imem_addr); end
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0000_0013;
    tick;
    imem_rsp_valid = 1'b0;
    checks++; if (pc_out !== 32'hFFFF_FFFC || instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc got v=%b pc=%h exp v=1 pc=fffffffc", instr_valid, pc_out); end
    instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got v=%b a=%h exp v=1 a=0", imem_req_valid, imem_addr); end
  endtask
  task automatic test_reset_in_hold;
    redirect_valid = 1'b1;
    redirect_target = 32'h80;
    tick;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0010_0073;
    tick;
    imem_rsp_valid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h80) begin errors++; $display("FAIL rh_hold got v=%b pc=%h exp v=1 pc=80", instr_valid, pc_out); end
    rst = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0 || instr !== NOP_INSTR || pc_out !== RESET_PC || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rh_async got iv=%b %h pc=%h rv=%b exp iv=0 %h pc=%h rv=0", instr_valid, instr, pc_out, imem_req_valid, NOP_INSTR, RESET_PC);
    end
    tick;
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hCAFE_F00D;
    tick;
    imem_rsp_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL rh_release got iv=%b rv=%b a=%h exp iv=0 rv=1 a=%h", instr_valid, imem_req_valid, imem_addr, RESET_PC);
    end
  endtask
  task automatic test_random;
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] pend_addr;
    logic [31:0] s_instr;
    logic [31:0] s_pc;
    logic [31:0] s_addr;
    logic pend;
    logic hold_stall;
    logic req_stall;
    logic redir_hold;
    int pend_cnt;
    int consumed;
    exp_fetch = RESET_PC;
    exp_pc = RESET_PC;
    pend = 1'b0;
    pend_addr = 32'h0;
    pend_cnt = 0;
    hold_stall = 1'b0;
    req_stall = 1'b0;
    redir_hold = 1'b0;
    s_instr = 32'h0;
    s_pc = 32'h0;
    s_addr = 32'h0;
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_stall) begin
        checks++; if (instr_valid !== 1'b1 || instr !== s_instr || pc_out !== s_pc) begin
          errors++; $display("FAIL rnd_hold_stable c=%0d got v=%b %h pc=%h exp v=1 %h pc=%h", c, instr_valid, instr, pc_out, s_instr, s_pc);
        end
      end
      if (req_stall) begin
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== s_addr) begin
          errors++; $display("FAIL rnd_req_stable c=%0d got v=%b a=%h exp v=1 a=%h", c, imem_req_valid, imem_addr, s_addr);
        end
      end
      if (redir_hold) begin
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rnd_redir_hold c=%0d got iv=%b exp 0", c, instr_valid); end
      end
      checks++; if (imem_req_valid === 1'b1 && instr_valid === 1'b1) begin errors++; $display("FAIL rnd_exclusive c=%0d got rv=1 iv=1 exp not both", c); end
      imem_rsp_valid = 1'b0;
      imem_rsp_data = $urandom;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data = memfn(pend_addr);
          pend = 1'b0;
        end else pend_cnt--;
      end else imem_rsp_valid = $urandom_range(0, 7) == 0;
      imem_req_ready = $urandom_range(0, 2) != 0;
      instr_ready = $urandom_range(0, 2) != 0;
      redirect_valid = $urandom_range(0, 11) == 0;
      redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : ($urandom & 32'h0000_0FFF);
      if (imem_req_valid && imem_req_ready) begin
        checks++; if (imem_addr !== exp_fetch) begin errors++; $display("FAIL rnd_fetch_addr c=%0d got %h exp %h", c, imem_addr, exp_fetch); end
        exp_fetch = exp_fetch + 32'd4;
        pend = 1'b1;
        pend_addr = imem_addr;
        pend_cnt = $urandom_range(0, 2);
      end
      if (instr_valid && (instr_ready || redirect_valid)) begin
        exp_instr = memfn(exp_pc);
        checks++; if (pc_out !== exp_pc || instr !== exp_instr || opcode !== exp_instr[6:0]) begin
          errors++; $display("FAIL rnd_consume c=%0d got pc=%h %h op=%b exp pc=%h %h op=%b", c, pc_out, instr, opcode, exp_pc, exp_instr, exp_instr[6:0]);
        end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (redirect_valid) begin
        exp_fetch = redirect_target & ~32'd3;
        exp_pc = redirect_target & ~32'd3;
      end
      hold_stall = instr_valid && !instr_ready && !redirect_valid;
      req_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
      redir_hold = instr_valid && redirect_valid;
      s_instr = instr;
      s_pc = pc_out;
      s_addr = imem_addr;
      tick;
    end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (consumed < 50) begin errors++; $display("FAIL rnd_progress got %0d exp >=50", consumed); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_redirect_handshake;
    test_redirect_wait;
    test_wrap;
    test_reset_in_hold;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
